// File: rtl/tc_psum_feeder.sv
// Partial-sum feeder: turns TILE_M-wide PE beats into positional accumulator
// writes, walking col -> row -> pass, then requests readout and waits out the drain.
module tc_psum_feeder #(
    parameter int M        = 16,
    parameter int N        = 16,
    parameter int TILE_M   = 4,
    parameter int DW_DATA  = 8,
    parameter int DW_POS   = 4,
    parameter int K_PASSES = 2,
    parameter int DRAIN    = 18
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [TILE_M*DW_DATA-1:0] s_data,
    output logic [DW_POS-1:0]         row,
    output logic [DW_POS-1:0]         col,
    output logic [TILE_M*DW_DATA-1:0] in,
    output logic                      input_en,
    output logic                      out_en,
    output logic                      busy,
    output logic                      done
);

    localparam int BW  = TILE_M * DW_DATA;
    localparam int PW  = (K_PASSES > 1) ? $clog2(K_PASSES) : 1;
    localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    localparam logic [DW_POS-1:0] C_LAST = DW_POS'(N - 1);
    localparam logic [DW_POS-1:0] R_LAST = DW_POS'(M - TILE_M);
    localparam logic [DW_POS-1:0] R_STEP = DW_POS'(TILE_M);
    localparam logic [PW-1:0]     P_LAST = PW'(K_PASSES - 1);
    localparam logic [DCW-1:0]    D_LOAD = DCW'(DRAIN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LEAD,
        S_RUN,
        S_OUTREQ,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [DW_POS-1:0] c_q, c_d;
    logic [DW_POS-1:0] r_q, r_d;
    logic [PW-1:0]     p_q, p_d;
    logic [DCW-1:0]    dcnt_q, dcnt_d;

    logic              rdy_q;
    logic [DW_POS-1:0] row_q;
    logic [DW_POS-1:0] col_q;
    logic [BW-1:0]     data_q;
    logic              in_en_q;
    logic              out_en_q;
    logic              busy_q;
    logic              done_q;

    logic accept;
    logic last_beat;

    // rdy_q is high exactly while in RUN, so it doubles as the accept gate
    assign accept    = s_valid & rdy_q;
    assign last_beat = (c_q == C_LAST) && (r_q == R_LAST) && (p_q == P_LAST);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        p_d     = p_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ARM;
            end
            S_ARM:  state_d = S_LEAD;
            S_LEAD: state_d = S_RUN;
            S_RUN: begin
                if (accept) begin
                    if (last_beat) begin
                        state_d = S_OUTREQ;
                        c_d     = '0;
                        r_d     = '0;
                        p_d     = '0;
                    end else if (c_q != C_LAST) begin
                        c_d = c_q + 1'b1;
                    end else begin
                        c_d = '0;
                        if (r_q != R_LAST) begin
                            r_d = r_q + R_STEP;
                        end else begin
                            r_d = '0;
                            p_d = p_q + 1'b1;
                        end
                    end
                end
            end
            S_OUTREQ: begin
                state_d = S_DRAIN;
                dcnt_d  = D_LOAD;
            end
            S_DRAIN: begin
                if (dcnt_q == '0) state_d = S_IDLE;
                else              dcnt_d  = dcnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            c_q      <= '0;
            r_q      <= '0;
            p_q      <= '0;
            dcnt_q   <= '0;
            rdy_q    <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
            data_q   <= '0;
            in_en_q  <= 1'b0;
            out_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            r_q      <= r_d;
            p_q      <= p_d;
            dcnt_q   <= dcnt_d;
            rdy_q    <= (state_d == S_RUN);
            in_en_q  <= (state_d == S_ARM);
            out_en_q <= (state_d == S_OUTREQ);
            busy_q   <= (state_d != S_IDLE);
            done_q   <= (state_d == S_DRAIN) && (dcnt_d == '0);
            // accumulator adds every cycle, so idle cycles must carry zeros
            data_q   <= accept ? s_data : '0;
            if (accept) begin
                row_q <= r_q;
                col_q <= c_q;
            end
        end
    end

    assign s_ready  = rdy_q;
    assign row      = row_q;
    assign col      = col_q;
    assign in       = data_q;
    assign input_en = in_en_q;
    assign out_en   = out_en_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
